// File: rtl/key_pkg.sv
// Shared defaults for the multi-channel key debouncer: channel count, counter
// widths and the released (idle) key level.
package key_pkg;

    localparam int   CH_DEF         = 4;
    localparam int   CNT_W_DEF      = 20;
    localparam int   HOLD_W_DEF     = 28;
    localparam logic IDLE_LEVEL_DEF = 1'b1;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce counter, edge pulses and
// long-press detection with a saturating hold counter.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int   CNT_W      = CNT_W_DEF,
    parameter int   HOLD_W     = HOLD_W_DEF,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_in,
    input  logic [CNT_W-1:0]  cfg_deb_ticks,
    input  logic [HOLD_W-1:0] cfg_long_ticks,
    output logic              key_state,
    output logic              key_press,
    output logic              key_release,
    output logic              key_long,
    output logic              key_held
);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              state_q, state_d;
    logic [CNT_W-1:0]  deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              held_q, held_d;
    logic              commit;
    logic              pressed_next;
    logic              long_en;

    always_comb begin
        s1_d    = key_in;
        s2_d    = s1_q;
        state_d = state_q;
        deb_d   = deb_q;
        // >= compare lets a lowered threshold commit a long-running count at once
        if (s2_q == state_q) begin
            deb_d = '0;
        end else if (deb_q >= cfg_deb_ticks) begin
            state_d = s2_q;
            deb_d   = '0;
        end else begin
            deb_d = deb_q + 1'b1;
        end

        commit       = (state_d != state_q);
        pressed_next = (state_d != IDLE_LEVEL);
        press_d      = commit && pressed_next;
        release_d    = commit && !pressed_next;
        long_en      = (cfg_long_ticks != '0);

        if (!pressed_next || press_d) begin
            hold_d = '0;
        end else if (hold_q < cfg_long_ticks) begin
            hold_d = hold_q + 1'b1;
        end else begin
            hold_d = hold_q;
        end

        // Gating on pressed_next makes a same-cycle release suppress the long pulse
        long_d = long_en && pressed_next && !press_d
                 && (hold_q < cfg_long_ticks) && (hold_d == cfg_long_ticks);
        held_d = long_en && pressed_next && !press_d && (hold_d >= cfg_long_ticks);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= IDLE_LEVEL;
            s2_q      <= IDLE_LEVEL;
            state_q   <= IDLE_LEVEL;
            deb_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_held    = held_q;

endmodule

// File: rtl/key_debounce_mc.sv
// Multi-channel key debouncer: CH independent key_debounce_ch instances
// sharing the debounce and long-press thresholds.
module key_debounce_mc
    import key_pkg::*;
#(
    parameter int   CH         = CH_DEF,
    parameter int   CNT_W      = CNT_W_DEF,
    parameter int   HOLD_W     = HOLD_W_DEF,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     key_in,
    input  logic [CNT_W-1:0]  cfg_deb_ticks,
    input  logic [HOLD_W-1:0] cfg_long_ticks,
    output logic [CH-1:0]     key_state,
    output logic [CH-1:0]     key_press,
    output logic [CH-1:0]     key_release,
    output logic [CH-1:0]     key_long,
    output logic [CH-1:0]     key_held
);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            key_debounce_ch #(
                .CNT_W      (CNT_W),
                .HOLD_W     (HOLD_W),
                .IDLE_LEVEL (IDLE_LEVEL)
            ) u_ch (
                .clk            (clk),
                .rst_n          (rst_n),
                .key_in         (key_in[gi]),
                .cfg_deb_ticks  (cfg_deb_ticks),
                .cfg_long_ticks (cfg_long_ticks),
                .key_state      (key_state[gi]),
                .key_press      (key_press[gi]),
                .key_release    (key_release[gi]),
                .key_long       (key_long[gi]),
                .key_held       (key_held[gi])
            );
        end
    endgenerate

endmodule

// File: doc/key_debounce_mc.md
KEY_DEBOUNCE_MC -- requirements
Module: key_debounce_mc

Interface
REQ-001 SHALL provide parameter CH, default 4, number of independent key channels (1..32).
REQ-002 SHALL provide parameter CNT_W, default 20, debounce counter width.
REQ-003 SHALL provide parameter HOLD_W, default 28, long-press counter width.
REQ-004 SHALL provide parameter IDLE_LEVEL, default 1'b1, released (idle) level of every key; pressed level = ~IDLE_LEVEL.
REQ-005 SHALL provide ports: clk  input  1  system clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_in  input  CH  raw asynchronous key levels.
REQ-008 cfg_deb_ticks  input  CNT_W  debounce threshold in clk cycles, sampled every cycle.
REQ-009 cfg_long_ticks  input  HOLD_W  long-press threshold in clk cycles; 0 disables long-press.
REQ-010 key_state  output  CH  debounced level per channel.
REQ-011 key_press  output  CH  one-cycle pulse on debounced transition idle->pressed.
REQ-012 key_release  output  CH  one-cycle pulse on debounced transition pressed->idle.
REQ-013 key_long  output  CH  one-cycle pulse when press held cfg_long_ticks cycles.
REQ-014 key_held  output  CH  level, high while pressed and long threshold reached.

Function (per channel, channels fully independent)
REQ-015 key_in SHALL pass a 2-flop synchronizer (s1, s2) before any use.
REQ-016 If s2 == key_state, debounce counter SHALL clear to 0.
REQ-017 If s2 != key_state and counter >= cfg_deb_ticks, key_state SHALL load s2 and counter SHALL clear.
REQ-018 If s2 != key_state and counter < cfg_deb_ticks, counter SHALL increment by 1; never wraps.
REQ-019 Latency: stable input change to key_state change SHALL be exactly cfg_deb_ticks+3 cycles; cfg_deb_ticks=0 gives 3 cycles (no filtering).
REQ-020 Any s2 return to key_state before threshold SHALL discard the pending change (glitch rejected, no pulse).
REQ-021 Lowering cfg_deb_ticks below a running count SHALL commit on the next cycle (>= compare).
REQ-022 key_press/key_release SHALL be registered, asserted for one cycle coincident with the key_state update cycle, mutually exclusive.
REQ-023 Hold counter SHALL clear on key_press cycle and whenever key_state is idle.
REQ-024 While pressed and hold counter < cfg_long_ticks, hold counter SHALL increment; saturates at cfg_long_ticks.
REQ-025 key_long SHALL pulse once in the cycle hold counter reaches cfg_long_ticks, i.e. cfg_long_ticks cycles after key_press; at most once per press.
REQ-026 key_held SHALL be high from the key_long cycle until key_release cycle inclusive-exclusive (low on release cycle).
REQ-027 cfg_long_ticks=0 SHALL force key_long and key_held low.
REQ-028 Release and long threshold in same cycle: release wins, no key_long.

Reset
REQ-029 On rst_n low: s1, s2, key_state SHALL equal {CH{IDLE_LEVEL}}; all counters 0; key_press, key_release, key_long, key_held 0.
REQ-030 Reset mid-debounce or mid-hold SHALL discard progress; no pulses SHALL emit after reset release unless key_in differs from IDLE_LEVEL for cfg_deb_ticks+3 cycles.

Structure
REQ-031 Default parameter values and IDLE_LEVEL constant SHALL live in shared package key_pkg.
REQ-032 Per-channel logic SHALL be sub-module key_debounce_ch, instantiated CH times via generate; top contains no logic beyond wiring.
REQ-033 Only state elements: s1, s2, key_state, debounce counter, hold counter, output pulse registers per channel.

Verification (CH=4, IDLE_LEVEL=1, cfg_deb_ticks=500, cfg_long_ticks=2000)
REQ-034 key_in[0] 1->0 held -> key_state[0]=0 and key_press[0] single pulse exactly 503 cycles after input edge; other channels unchanged.
REQ-035 key_in[1] low 300 cycles then high -> no key_state change, no pulses.
REQ-036 key_in[2] held low 3000 cycles -> key_long[2] pulse 2000 cycles after key_press[2], key_held[2] high until key_release[2].
REQ-037 cfg_deb_ticks=0, key_in[3] toggle -> key_state[3] follows after 3 cycles; cfg_long_ticks=0 -> key_long never asserts.
REQ-038 rst_n asserted at debounce count 250 then released with key_in low -> outputs idle, press reported 503 cycles after release.
REQ-039 All four channels pressed same cycle -> four simultaneous key_press pulses.
